// File: rtl/nw_pkg.sv
// Shared Needleman-Wunsch definitions: score format, scoring constants,
// direction symbols and a saturating adder. The symbol values are also
// decoded by the traceback stage, so they must not change independently.
package nw_pkg;

    localparam int unsigned SCORE_W = 9;

    typedef logic signed [SCORE_W-1:0] score_t;
    typedef logic [2:0]                symbol_t;

    localparam score_t SCORE_MAX = 9'sh0FF;  // +255
    localparam score_t SCORE_MIN = 9'sh100;  // -256

    localparam score_t MATCH    =  9'sd1;
    localparam score_t MISMATCH = -9'sd1;
    localparam score_t GAP      = -9'sd2;

    localparam symbol_t SYM_NONE = 3'b000;
    localparam symbol_t SYM_DIAG = 3'b001;
    localparam symbol_t SYM_UP   = 3'b010;
    localparam symbol_t SYM_LEFT = 3'b100;

    // StDrain covers the single cycle in which the last cell's write is
    // still on the output registers, so end_fill never overlaps we.
    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StDrain,
        StDone
    } fill_state_e;

    // Signed add clamped to [SCORE_MIN, SCORE_MAX]. The sum is formed one
    // bit wider; differing top two bits mean it left the 9-bit range.
    function automatic score_t sat_add(input score_t a, input score_t b);
        logic signed [SCORE_W:0] sum;
        sum = {a[SCORE_W-1], a} + {b[SCORE_W-1], b};
        if (sum[SCORE_W] != sum[SCORE_W-1]) begin
            return sum[SCORE_W] ? SCORE_MIN : SCORE_MAX;
        end
        return sum[SCORE_W-1:0];
    endfunction

endpackage

// File: rtl/nw_cell_score.sv
// Combinational score of one interior matrix cell.
//   diag_i   H(i-1,j-1)      up_i   H(i-1,j)      left_i  H(i,j-1)
//   match_i  sequence characters equal
//   score_o  max of the three saturated candidates
//   symbol_o direction of the winner; ties resolve DIAG > UP > LEFT
module nw_cell_score
    import nw_pkg::*;
(
    input  logic signed [SCORE_W-1:0] diag_i,
    input  logic signed [SCORE_W-1:0] up_i,
    input  logic signed [SCORE_W-1:0] left_i,
    input  logic                      match_i,
    output logic signed [SCORE_W-1:0] score_o,
    output logic [2:0]                symbol_o
);

    score_t cand_d;
    score_t cand_u;
    score_t cand_l;

    always_comb begin
        cand_d = sat_add(diag_i, match_i ? MATCH : MISMATCH);
        cand_u = sat_add(up_i, GAP);
        cand_l = sat_add(left_i, GAP);

        score_o  = cand_d;
        symbol_o = SYM_DIAG;
        if (cand_d >= cand_u && cand_d >= cand_l) begin
            score_o  = cand_d;
            symbol_o = SYM_DIAG;
        end else if (cand_u >= cand_l) begin
            score_o  = cand_u;
            symbol_o = SYM_UP;
        end else begin
            score_o  = cand_l;
            symbol_o = SYM_LEFT;
        end
    end

endmodule

// File: rtl/nw_matrix_filler.sv
// Fill stage of the Needleman-Wunsch engine. Sweeps cells (i,j) of the
// (N+1)x(N+1) matrix row-major, one per cycle, and writes each cell's score
// and direction symbol one cycle later on the registered wr_* port.
//   clk, rst        clock, synchronous active-high reset
//   en_fill         start level, sampled only in idle; low again leaves done
//   SeqA_i, SeqB_j  sequence characters at i_ram / j_ram (same-cycle read)
//   i_ram, j_ram    sequence read addresses, i-1 / j-1 (0 on the boundary)
//   we, wr_*        matrix write strobe, row, column, symbol, score
//   busy            sweep in progress
//   end_fill        sweep complete, held until en_fill drops
//   final_score     H(N,N), valid while end_fill is high
// The previous score row lives in prev_q, so scores are never read back.
module nw_matrix_filler
    import nw_pkg::*;
#(
    parameter int unsigned N       = 128,
    parameter int unsigned BitAddr = $clog2(N + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en_fill,
    input  logic [2:0]                SeqA_i,
    input  logic [2:0]                SeqB_j,
    output logic [BitAddr:0]          i_ram,
    output logic [BitAddr:0]          j_ram,
    output logic                      we,
    output logic [BitAddr:0]          wr_i,
    output logic [BitAddr:0]          wr_j,
    output logic [2:0]                wr_symbol,
    output logic signed [SCORE_W-1:0] wr_score,
    output logic                      busy,
    output logic                      end_fill,
    output logic signed [SCORE_W-1:0] final_score
);

    localparam int unsigned         IdxW    = BitAddr + 1;
    localparam logic [IdxW-1:0]     LastIdx = IdxW'(N);

    fill_state_e     state_q, state_d;
    logic [IdxW-1:0] i_q, i_d;
    logic [IdxW-1:0] j_q, j_d;
    score_t          diag_q, diag_d;
    score_t          left_q, left_d;
    score_t          prev_q [0:N];

    logic            we_q, we_d;
    logic [IdxW-1:0] wr_i_q, wr_i_d;
    logic [IdxW-1:0] wr_j_q, wr_j_d;
    symbol_t         wr_symbol_q, wr_symbol_d;
    score_t          wr_score_q, wr_score_d;
    logic            busy_q, busy_d;
    logic            end_fill_q, end_fill_d;
    score_t          final_score_q, final_score_d;

    logic [BitAddr-1:0] j_idx;
    score_t             up_score;
    score_t             core_score;
    symbol_t            core_symbol;
    score_t             cell_score;
    symbol_t            cell_symbol;

    assign j_idx    = j_q[BitAddr-1:0];
    assign up_score = prev_q[j_idx];

    assign i_ram = (i_q == '0) ? '0 : i_q - IdxW'(1);
    assign j_ram = (j_q == '0) ? '0 : j_q - IdxW'(1);

    nw_cell_score u_cell_score (
        .diag_i   (diag_q),
        .up_i     (up_score),
        .left_i   (left_q),
        .match_i  (SeqA_i == SeqB_j),
        .score_o  (core_score),
        .symbol_o (core_symbol)
    );

    // Boundary cells are built by repeated saturating GAP adds from their
    // neighbour, which equals the saturated k*GAP without a multiplier.
    always_comb begin
        cell_score  = core_score;
        cell_symbol = core_symbol;
        if (i_q == '0 && j_q == '0) begin
            cell_score  = '0;
            cell_symbol = SYM_NONE;
        end else if (i_q == '0) begin
            cell_score  = sat_add(left_q, GAP);
            cell_symbol = SYM_LEFT;
        end else if (j_q == '0) begin
            cell_score  = sat_add(up_score, GAP);
            cell_symbol = SYM_UP;
        end
    end

    always_comb begin
        state_d       = state_q;
        i_d           = i_q;
        j_d           = j_q;
        diag_d        = diag_q;
        left_d        = left_q;
        we_d          = 1'b0;
        wr_i_d        = '0;
        wr_j_d        = '0;
        wr_symbol_d   = SYM_NONE;
        wr_score_d    = '0;
        final_score_d = final_score_q;

        unique case (state_q)
            StIdle: begin
                if (en_fill) begin
                    state_d = StFill;
                    i_d     = '0;
                    j_d     = '0;
                end
            end
            StFill: begin
                we_d        = 1'b1;
                wr_i_d      = i_q;
                wr_j_d      = j_q;
                wr_symbol_d = cell_symbol;
                wr_score_d  = cell_score;
                // Old prev[j] is H(i-1,j): the diagonal of the next cell.
                diag_d      = up_score;
                left_d      = cell_score;
                if (j_q == LastIdx) begin
                    j_d = '0;
                    if (i_q == LastIdx) begin
                        i_d           = '0;
                        state_d       = StDrain;
                        final_score_d = cell_score;
                    end else begin
                        i_d = i_q + IdxW'(1);
                    end
                end else begin
                    j_d = j_q + IdxW'(1);
                end
            end
            StDrain: begin
                state_d = StDone;
            end
            StDone: begin
                if (!en_fill) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d     = (state_d == StFill) || (state_d == StDrain);
        end_fill_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            i_q           <= '0;
            j_q           <= '0;
            diag_q        <= '0;
            left_q        <= '0;
            we_q          <= 1'b0;
            wr_i_q        <= '0;
            wr_j_q        <= '0;
            wr_symbol_q   <= SYM_NONE;
            wr_score_q    <= '0;
            busy_q        <= 1'b0;
            end_fill_q    <= 1'b0;
            final_score_q <= '0;
        end else begin
            state_q       <= state_d;
            i_q           <= i_d;
            j_q           <= j_d;
            diag_q        <= diag_d;
            left_q        <= left_d;
            we_q          <= we_d;
            wr_i_q        <= wr_i_d;
            wr_j_q        <= wr_j_d;
            wr_symbol_q   <= wr_symbol_d;
            wr_score_q    <= wr_score_d;
            busy_q        <= busy_d;
            end_fill_q    <= end_fill_d;
            final_score_q <= final_score_d;
        end
    end

    // Row buffer is never cleared: row 0 is recomputed on every sweep
    // before any later row reads it.
    always_ff @(posedge clk) begin
        if (state_q == StFill) begin
            prev_q[j_idx] <= cell_score;
        end
    end

    assign we          = we_q;
    assign wr_i        = wr_i_q;
    assign wr_j        = wr_j_q;
    assign wr_symbol   = wr_symbol_q;
    assign wr_score    = wr_score_q;
    assign busy        = busy_q;
    assign end_fill    = end_fill_q;
    assign final_score = final_score_q;

endmodule
